jtpopeye_objdma: RTL and testbench

JTPOPEYE_OBJDMA -- requirements
Module: jtpopeye_objdma

---
 rtl/jtpopeye_objdma.sv | 113 +++++++++++
 tb/tb_jtpopeye_objdma.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/jtpopeye_objdma.sv
// Sprite DMA: copies one 256-byte RAM page into a 64-entry x 29-bit object table,
// then scans the table out to the line-buffer writer (DO blanked while a copy runs).
module jtpopeye_objdma #(
  parameter int BASEW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             H0_cen,
  input  logic             dma_trig,
  input  logic [BASEW-1:0] dma_page,
  output logic [BASEW+7:0] ram_addr,
  input  logic [7:0]       ram_data,
  output logic             busy,
  output logic             done,
  input  logic [7:0]       H,
  input  logic             HB,
  output logic [28:0]      DO
);

  typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;

  state_t           state_q;
  logic [7:0]       cnt_q;
  logic [7:0]       cnt_d;
  logic [7:0]       cap_idx;
  logic [BASEW-1:0] page_q;
  logic [23:0]      stage_q;
  logic             trig_q;
  logic             arm_q;
  logic             busy_q;
  logic             done_q;
  logic [BASEW+7:0] addr_q;
  logic [28:0]      do_q;
  logic [28:0]      tbl [0:63];

  logic trig_rise;
  logic accept;
  logic capture;
  logic wr_en;

  assign cnt_d     = cnt_q + 8'd1;
  assign cap_idx   = cnt_q - 8'd1;
  // arm_q blocks a trigger that was already high when reset released
  assign trig_rise = dma_trig & ~trig_q & arm_q;
  assign accept    = (state_q == IDLE) & trig_rise & ~done_q;
  assign capture   = ((state_q == READ) & (cnt_q != 8'd0)) | (state_q == FLUSH);
  assign wr_en     = capture & (cap_idx[1:0] == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      page_q  <= '0;
      stage_q <= 24'd0;
      trig_q  <= 1'b0;
      arm_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      do_q    <= 29'd0;
    end else begin
      trig_q <= dma_trig;
      arm_q  <= arm_q | ~dma_trig;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= READ;
            busy_q  <= 1'b1;
            cnt_q   <= 8'd0;
            page_q  <= dma_page;
            addr_q  <= {dma_page, 8'd0};
          end
        end
        READ: begin
          cnt_q <= cnt_d;
          if (cnt_q == 8'hFF) state_q <= FLUSH;
          else addr_q <= {page_q, cnt_d};
        end
        FLUSH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase

      if (capture) begin
        case (cap_idx[1:0])
          2'd0:    stage_q[7:0]   <= ram_data;
          2'd1:    stage_q[15:8]  <= ram_data;
          2'd2:    stage_q[23:16] <= ram_data;
          default: ;
        endcase
      end

      // Blank from the accept edge so no half-written object is ever scanned out
      if (accept || busy_q) do_q <= 29'd0;
      else if (H0_cen && (H[1:0] == 2'b00)) do_q <= HB ? 29'd0 : tbl[H[7:2]];
    end
  end

  // Table survives reset; an entry is committed only once its last byte arrives
  always_ff @(posedge clk) begin
    if (wr_en) tbl[cap_idx[7:2]] <= {ram_data[4:0], stage_q};
  end

  assign ram_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign DO       = do_q;

endmodule

// File: tb/tb_jtpopeye_objdma.sv
// Randomized bench for jtpopeye_objdma with a clock-indexed transfer model and RAM model.
module tb_jtpopeye_objdma;
  localparam int BASEW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             H0_cen;
  logic             dma_trig;
  logic [BASEW-1:0] dma_page;
  logic [BASEW+7:0] ram_addr;
  logic [7:0]       ram_data;
  logic             busy;
  logic             done;
  logic [7:0]       H;
  logic             HB;
  logic [28:0]      DO;

  logic [7:0]  mem [0:1023];
  int          vectors = 0;
  int          miscompares = 0;

  // Reference model: a transfer is tracked by clocks elapsed since acceptance
  bit          m_busy, m_done, m_prev;
  int          m_t, m_page, m_addr;
  logic [28:0] m_do;
  logic [28:0] m_tbl [0:63];

  always #5 clk = ~clk;
  always @(posedge clk) ram_data <= mem[ram_addr];

  jtpopeye_objdma #(.BASEW(BASEW)) dut (
    .clk(clk), .rst(rst), .H0_cen(H0_cen), .dma_trig(dma_trig), .dma_page(dma_page),
    .ram_addr(ram_addr), .ram_data(ram_data), .busy(busy), .done(done),
    .H(H), .HB(HB), .DO(DO)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [28:0] entry_of(input int page, input int e);
    int base;
    base = page * 256 + 4 * e;
    return {mem[base+3][4:0], mem[base+2], mem[base+1], mem[base]};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_t = 0; m_page = 0; m_addr = 0; m_do = 29'd0;
    m_prev = 1;  // post-reset history counts as "high": a fresh low-to-high is required
  endtask

  task automatic model_step();
    bit rise, was_done;
    if (rst) begin
      model_reset();
      return;
    end
    rise   = dma_trig && !m_prev;
    m_prev = dma_trig;
    if (m_busy) begin
      // byte t-1 lands at the end of clock t, so entry e completes at t = 4e+4
      if (m_t >= 4 && (m_t % 4) == 0) m_tbl[m_t/4 - 1] = entry_of(m_page, m_t/4 - 1);
      if (m_t < 255) m_addr = m_page * 256 + m_t + 1;
      m_do = 29'd0;
      if (m_t == 256) begin
        m_busy = 0;
        m_done = 1;
      end else begin
        m_t++;
      end
    end else begin
      was_done = m_done;
      m_done   = 0;
      if (rise && !was_done) begin
        m_busy = 1; m_t = 0; m_page = int'(dma_page); m_addr = m_page * 256; m_do = 29'd0;
      end else if (H0_cen && H[1:0] == 2'b00) begin
        m_do = HB ? 29'd0 : m_tbl[H[7:2]];
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("ram_addr", 32'(ram_addr), m_addr);
    chk("DO", 32'(DO), 32'(m_do));
  endtask

  task automatic fill_random();
    for (int k = 0; k < 1024; k++) mem[k] = 8'($urandom);
  endtask

  // mode 0 plain, 1 edge on done clk, 2 edge on clk after done, 3 edge mid-transfer
  task automatic run_xfer(input int page, input int mode, input string tag);
    int nbusy, ndone, done_i;
    nbusy = 0; ndone = 0; done_i = -10;
    dma_page = BASEW'(page);
    dma_trig = 1'b1;
    for (int i = 0; i < 600; i++) begin
      tick();
      dma_trig = 1'b0;
      if (busy) nbusy++;
      if (done) ndone++;
      if (m_done && done_i < 0) begin
        done_i = i;
        if (mode == 1) dma_trig = 1'b1;
      end
      if (mode == 2 && i == done_i + 1) dma_trig = 1'b1;
      if (mode == 3 && i == 99) dma_trig = 1'b1;
    end
    dma_trig = 1'b0;
    chk({tag, "_busy_clks"}, nbusy, (mode == 2) ? 514 : 257);
    chk({tag, "_done_pulses"}, ndone, (mode == 2) ? 2 : 1);
  endtask

  task automatic scan(input bit hb, input int trig_at);
    for (int h = 0; h < 256; h++) begin
      H = 8'(h); HB = hb; H0_cen = 1'b1;
      dma_trig = (h == trig_at);
      tick();
    end
    dma_trig = 1'b0;
  endtask

  initial begin
    logic [28:0] ent5;
    ent5 = {5'h17, 8'h16, 8'h15, 8'h14};
    rst = 1'b1; H0_cen = 1'b0; dma_trig = 1'b0; dma_page = '0; H = 8'd0; HB = 1'b1;
    fill_random();
    for (int e = 0; e < 64; e++) m_tbl[e] = 29'd0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Basic transfer from page 2 with an address-pattern RAM
    for (int k = 0; k < 1024; k++) mem[k] = 8'(k);
    run_xfer(2, 0, "basic");
    chk("basic_addr_end", 32'(ram_addr), 32'h2FF);
    H = 8'd20; HB = 1'b0; H0_cen = 1'b1;
    tick();
    chk("entry5", 32'(DO), 32'(ent5));
    scan(1'b0, -1);
    scan(1'b1, -1);
    scan(1'b0, -1);

    // Trigger during active display, then scan-out resumes
    fill_random();
    scan(1'b0, 100);
    scan(1'b0, -1);
    scan(1'b0, -1);

    // Retrigger rules
    run_xfer(1, 3, "retrig_mid");
    run_xfer(0, 1, "retrig_doneclk");
    run_xfer(2, 2, "retrig_after");

    // Reset in the middle of a transfer, trigger held high through it
    fill_random();
    dma_page = 2'd1; dma_trig = 1'b1;
    tick();
    dma_trig = 1'b0;
    for (int i = 0; i < 300 && !(m_busy && m_t == 130); i++) tick();
    chk("rst_reach_cnt130", m_t, 130);
    chk("rst_pre_addr", 32'(ram_addr), 32'h182);
    dma_trig = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_async_busy", 32'(busy), 0);
    chk("rst_async_done", 32'(done), 0);
    chk("rst_async_DO", 32'(DO), 0);
    chk("rst_async_addr", 32'(ram_addr), 0);
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();
    dma_trig = 1'b0;
    tick();
    scan(1'b0, -1);

    // Page 3 wrap with b3 = FF in every entry
    fill_random();
    for (int e = 0; e < 64; e++) mem[3*256 + 4*e + 3] = 8'hFF;
    run_xfer(3, 0, "wrap");
    chk("wrap_addr_end", 32'(ram_addr), 32'h3FF);
    H = 8'd28; HB = 1'b0; H0_cen = 1'b1;
    tick();
    chk("wrap_b3_field", 32'(DO[28:24]), 32'h1F);
    scan(1'b0, -1);

    // Random traffic: triggers, page, pixel enable, blanking, occasional reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) dma_trig = ~dma_trig;
      dma_page = BASEW'($urandom);
      H0_cen   = 1'($urandom_range(0, 1));
      if (H0_cen) H = H + 8'd1;
      HB  = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; dma_trig = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
